// File: rtl/multi_producer_fsm_pkg.sv
// Shared types and default parameter values for the multi-channel stimulus producer.
package multi_producer_fsm_pkg;

  // Per-channel control state; encodings are fixed so waveforms read the same everywhere.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DONE  = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  localparam int unsigned DEF_NUM_CH       = 2;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_STRIDE       = 2;
  localparam int unsigned DEF_FLUSH_CYCLES = 2;
  localparam int unsigned DEF_BURST_W      = 8;

endpackage

// File: rtl/multi_producer_fsm_channel.sv
// One producer channel: arithmetic sequence SEED + k*STRIDE with stall hold,
// optional bounded bursts and a fixed-length flush sequence that rewinds the sequence.
module multi_producer_fsm_channel
  import multi_producer_fsm_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STRIDE       = DEF_STRIDE,
  parameter int unsigned SEED         = 0,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int unsigned BURST_W      = DEF_BURST_W
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               stall_i,
  input  logic               flush_req_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               in_valid_o,
  output logic               flush_o,
  output logic               done_o
);

  // Timer counts down FLUSH_CYCLES-1 .. 0, so it only needs to hold FLUSH_CYCLES-1.
  localparam int unsigned TMR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [DATA_W-1:0] SEED_V   = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] STRIDE_V = DATA_W'(STRIDE);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [BURST_W-1:0] sent_q, sent_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               valid_q, valid_d;
  logic               flush_q, flush_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] sent_inc_s;

  assign sent_inc_s = sent_q + BURST_W'(1);

  // Next-state and next-output logic; outputs default low so every state is explicit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sent_d  = sent_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    valid_d = 1'b0;
    flush_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = SEED_V;
          sent_d  = '0;
          len_d   = burst_len_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush_req_i) begin
          state_d = ST_FLUSH;
          cnt_d   = SEED_V;
          sent_d  = '0;
          tmr_d   = TMR_LOAD;
          flush_d = 1'b1;
        end else if (stall_i) begin
          state_d = ST_RUN;
        end else begin
          data_d  = cnt_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + STRIDE_V;
          // Unbounded bursts (len 0) never count issues.
          if (len_q != '0) begin
            sent_d = sent_inc_s;
            if (sent_inc_s == len_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        // Flush outranks restart when both arrive together.
        if (flush_req_i) begin
          state_d = ST_FLUSH;
          cnt_d   = SEED_V;
          sent_d  = '0;
          tmr_d   = TMR_LOAD;
          flush_d = 1'b1;
        end else if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = SEED_V;
          sent_d  = '0;
          len_d   = burst_len_i;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Requests are ignored here; the sequence always lasts exactly FLUSH_CYCLES.
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
          tmr_d   = tmr_q - TMR_W'(1);
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset returns the channel to its seed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= SEED_V;
      data_q  <= '0;
      sent_q  <= '0;
      len_q   <= '0;
      tmr_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
      len_q   <= len_d;
      tmr_q   <= tmr_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  assign out_data_o = data_q;
  assign in_valid_o = valid_q;
  assign flush_o    = flush_q;
  assign done_o     = done_q;

endmodule

// File: rtl/multi_producer_fsm.sv
// N-channel stimulus producer: one independent channel per pipeline, channel i seeded with i.
module multi_producer_fsm
  import multi_producer_fsm_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STRIDE       = DEF_STRIDE,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int unsigned BURST_W      = DEF_BURST_W
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic [BURST_W-1:0]       burst_len_i,
  input  logic [NUM_CH-1:0]        stall_i,
  input  logic [NUM_CH-1:0]        flush_req_i,
  output logic [NUM_CH*DATA_W-1:0] out_data_o,
  output logic [NUM_CH-1:0]        in_valid_o,
  output logic [NUM_CH-1:0]        flush_o,
  output logic [NUM_CH-1:0]        done_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_producer_fsm_channel #(
      .DATA_W       (DATA_W),
      .STRIDE       (STRIDE),
      .SEED         (i),
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .BURST_W      (BURST_W)
    ) u_ch (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .start_i     (start_i),
      .burst_len_i (burst_len_i),
      .stall_i     (stall_i[i]),
      .flush_req_i (flush_req_i[i]),
      .out_data_o  (out_data_o[i*DATA_W +: DATA_W]),
      .in_valid_o  (in_valid_o[i]),
      .flush_o     (flush_o[i]),
      .done_o      (done_o[i])
    );
  end

endmodule

// File: tb/tb_multi_producer_fsm.sv
module tb_multi_producer_fsm;

  logic        clk;
  // 32-bit instance
  logic        reset_n;
  logic        start;
  logic [7:0]  burst_len;
  logic [1:0]  stall;
  logic [1:0]  flush_req;
  logic [63:0] out_data;
  logic [1:0]  in_valid;
  logic [1:0]  flush;
  logic [1:0]  done;
  // 4-bit instance for wrap checks
  logic        reset_n_w;
  logic        start_w;
  logic [7:0]  out_data_w;
  logic [1:0]  in_valid_w;
  logic [1:0]  flush_w;
  logic [1:0]  done_w;

  int checks;
  int failures;

  multi_producer_fsm #(
    .NUM_CH(2), .DATA_W(32), .STRIDE(2), .FLUSH_CYCLES(2), .BURST_W(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .burst_len_i(burst_len),
    .stall_i(stall), .flush_req_i(flush_req), .out_data_o(out_data),
    .in_valid_o(in_valid), .flush_o(flush), .done_o(done)
  );

  multi_producer_fsm #(
    .NUM_CH(2), .DATA_W(4), .STRIDE(2), .FLUSH_CYCLES(2), .BURST_W(8)
  ) dut_w (
    .clk_i(clk), .reset_n_i(reset_n_w), .start_i(start_w), .burst_len_i(8'd0),
    .stall_i(2'b00), .flush_req_i(2'b00), .out_data_o(out_data_w),
    .in_valid_o(in_valid_w), .flush_o(flush_w), .done_o(done_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    start     = 1'b0;
    burst_len = 8'd0;
    stall     = 2'b00;
    flush_req = 2'b00;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] len);
    burst_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_data, in_valid, flush, done} !== 70'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {out_data, in_valid, flush, done});
    end
  endtask

  task automatic test_free_run();
    do_reset();
    do_start(8'd0);
    checks++;
    if (in_valid !== 2'b00) begin
      failures++;
      $display("FAIL free_run_start_edge valid got=%b exp=00", in_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_data !== {32'(2*k+1), 32'(2*k)} || in_valid !== 2'b11) begin
        failures++;
        $display("FAIL free_run k=%0d got=%h v=%b exp=%h v=11", k, out_data, in_valid,
                 {32'(2*k+1), 32'(2*k)});
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    do_start(8'd0);
    tick(); tick(); tick(); // ch0 0,2,4 ; ch1 1,3,5
    stall = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (in_valid !== 2'b10 || out_data !== {32'(7+2*k), 32'd4}) begin
        failures++;
        $display("FAIL stall k=%0d got=%h v=%b exp=%h v=10", k, out_data, in_valid,
                 {32'(7+2*k), 32'd4});
      end
    end
    stall = 2'b00;
    tick();
    checks++;
    if (in_valid !== 2'b11 || out_data !== {32'd13, 32'd6}) begin
      failures++;
      $display("FAIL stall_resume got=%h v=%b exp=%h v=11", out_data, in_valid, {32'd13, 32'd6});
    end
  endtask

  task automatic test_burst();
    do_reset();
    do_start(8'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (in_valid !== 2'b11 || out_data !== {32'(2*k+1), 32'(2*k)}) begin
        failures++;
        $display("FAIL burst_issue k=%0d got=%h v=%b", k, out_data, in_valid);
      end
    end
    tick();
    checks++;
    if (in_valid !== 2'b00 || done !== 2'b11 || out_data !== {32'd5, 32'd4}) begin
      failures++;
      $display("FAIL burst_done got=%h v=%b d=%b exp=%h v=00 d=11",
               out_data, in_valid, done, {32'd5, 32'd4});
    end
    tick();
    checks++;
    if (in_valid !== 2'b00 || done !== 2'b11) begin
      failures++;
      $display("FAIL burst_done_hold v=%b d=%b exp v=00 d=11", in_valid, done);
    end
    do_start(8'd3);
    checks++;
    if (done !== 2'b00 || in_valid !== 2'b00) begin
      failures++;
      $display("FAIL burst_restart_edge v=%b d=%b exp v=00 d=00", in_valid, done);
    end
    tick();
    checks++;
    if (in_valid !== 2'b11 || out_data !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL burst_restart_data got=%h v=%b exp=%h", out_data, in_valid, {32'd1, 32'd0});
    end
  endtask

  task automatic test_flush();
    do_reset();
    do_start(8'd0);
    tick(); tick(); // ch0 0,2 ; ch1 1,3
    flush_req = 2'b10;
    tick(); // ch0 issues 4
    checks++;
    if (flush !== 2'b10 || in_valid !== 2'b01 || out_data[31:0] !== 32'd4) begin
      failures++;
      $display("FAIL flush_entry f=%b v=%b d0=%0d exp f=10 v=01 d0=4", flush, in_valid, out_data[31:0]);
    end
    tick(); // request still high: must not extend; ch0 6
    checks++;
    if (flush !== 2'b10 || in_valid !== 2'b01) begin
      failures++;
      $display("FAIL flush_hold f=%b v=%b exp f=10 v=01", flush, in_valid);
    end
    flush_req = 2'b00;
    tick(); // ch0 8
    checks++;
    if (flush !== 2'b00 || in_valid !== 2'b01) begin
      failures++;
      $display("FAIL flush_exit f=%b v=%b exp f=00 v=01", flush, in_valid);
    end
    do_start(8'd0); // ch0 10, ch1 IDLE -> RUN
    tick();         // ch0 12, ch1 seed 1
    checks++;
    if (in_valid !== 2'b11 || out_data !== {32'd1, 32'd12}) begin
      failures++;
      $display("FAIL flush_restart got=%h v=%b exp=%h v=11", out_data, in_valid, {32'd1, 32'd12});
    end
  endtask

  task automatic test_flush_on_last();
    do_reset();
    do_start(8'd2);
    tick(); // 0/1, one sent
    flush_req = 2'b01;
    tick(); // ch0 flushes instead of last issue; ch1 issues 3 and finishes
    checks++;
    if (flush !== 2'b01 || in_valid !== 2'b10 || done !== 2'b10 || out_data !== {32'd3, 32'd0}) begin
      failures++;
      $display("FAIL flush_last_entry f=%b v=%b d=%b data=%h exp f=01 v=10 d=10 data=%h",
               flush, in_valid, done, out_data, {32'd3, 32'd0});
    end
    flush_req = 2'b00;
    tick();
    checks++;
    if (flush !== 2'b01 || in_valid !== 2'b00 || done !== 2'b10) begin
      failures++;
      $display("FAIL flush_last_hold f=%b v=%b d=%b exp f=01 v=00 d=10", flush, in_valid, done);
    end
    tick();
    checks++;
    if (flush !== 2'b00 || in_valid !== 2'b00 || done !== 2'b10) begin
      failures++;
      $display("FAIL flush_last_exit f=%b v=%b d=%b exp f=00 v=00 d=10", flush, in_valid, done);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    reset_n_w = 1'b0;
    start_w = 1'b0;
    tick();
    reset_n_w = 1'b1;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++;
      if (out_data_w[7:4] !== 4'((1 + 2*k) % 16) || in_valid_w !== 2'b11) begin
        failures++;
        $display("FAIL wrap_ch1 k=%0d got=%0d v=%b exp=%0d", k, out_data_w[7:4], in_valid_w,
                 (1 + 2*k) % 16);
      end
    end
    #2;
    reset_n_w = 1'b0;
    #1;
    checks++;
    if ({out_data_w, in_valid_w, flush_w, done_w} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset_w got=%h exp=0", {out_data_w, in_valid_w, flush_w, done_w});
    end
    reset_n_w = 1'b1;
    // same on the wide instance, mid-burst
    do_reset();
    do_start(8'd0);
    tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_data, in_valid, flush, done} !== 70'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {out_data, in_valid, flush, done});
    end
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    reset_n_w = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    burst_len = 8'd0;
    stall = 2'b00;
    flush_req = 2'b00;
    test_reset();
    test_free_run();
    test_stall();
    test_burst();
    test_flush();
    test_flush_on_last();
    test_wrap_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
